flex_timer: RTL and testbench

- Parametrised successor to the team's flex counter: a prescaled up/down counter with wrap, one-shot and saturate modes, synchronous load, and a sticky done flag.
- Serves as the common timing primitive for bit-period generation, timeouts and frame/byte counting in the protocol and datapath blocks.
- Counting advances only on prescaler ticks, so one instance covers both slow and fast timing without external dividers.

---
 rtl/flex_timer_if.sv | 35 +++
 rtl/flex_timer.sv | 98 +++++++++
 tb/tb_flex_timer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/flex_timer_if.sv
// flex_timer_if: control and status bundle for flex_timer.
//   master : drives clear/load/load_val/count_enable/dir_down/mode/
//            prescale_val/rollover_val, observes the timer status.
//   slave  : the timer side; observes the controls and drives
//            count_out/tick/rollover_flag/done/active.
interface flex_timer_if #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
);
  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     dir_down;
  logic [1:0]               mode;
  logic [PRESCALE_BITS-1:0] prescale_val;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     tick;
  logic                     rollover_flag;
  logic                     done;
  logic                     active;

  modport master (
    output clear, load, load_val, count_enable, dir_down, mode,
           prescale_val, rollover_val,
    input  count_out, tick, rollover_flag, done, active
  );

  modport slave (
    input  clear, load, load_val, count_enable, dir_down, mode,
           prescale_val, rollover_val,
    output count_out, tick, rollover_flag, done, active
  );
endinterface

// File: rtl/flex_timer.sv
// flex_timer: prescaled up/down counter with wrap, one-shot and saturate
// modes, synchronous clear/load and a sticky done indication.
// Ports:
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   bus    : flex_timer_if.slave (controls in, count/tick/flag/done/active out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | prescaler and counter advance on enabled cycles
// ST_DONE | one-shot terminal reached; count and prescaler frozen
module flex_timer #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic      clk,
  input  logic      n_rst,
  flex_timer_if.slave bus
);

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_SATURATE = 2'b10;

  state_t                   state_q, state_n;
  logic [NUM_CNT_BITS-1:0]  count_q, count_n;
  logic [PRESCALE_BITS-1:0] pres_q, pres_n;
  logic                     tick_q, tick_n;
  logic                     flag_q, flag_n;

  logic [NUM_CNT_BITS-1:0]  term_val;
  logic                     at_term;

  assign term_val = bus.dir_down ? '0 : bus.rollover_val;
  assign at_term  = (count_q == term_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
      pres_q  <= '0;
      tick_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      pres_q  <= pres_n;
      tick_q  <= tick_n;
      flag_q  <= flag_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    pres_n  = pres_q;
    tick_n  = 1'b0;
    flag_n  = 1'b0;

    if (bus.clear) begin
      state_n = ST_RUN;
      count_n = '0;
      pres_n  = '0;
    end else if (bus.load) begin
      state_n = ST_RUN;
      count_n = bus.load_val;
      pres_n  = '0;
    end else if (state_q == ST_RUN && bus.count_enable) begin
      if (pres_q == bus.prescale_val) begin
        pres_n = '0;
        tick_n = 1'b1;
        if (!at_term) begin
          // modulo arithmetic: an up count loaded above rollover_val
          // runs through the maximum value back to 0
          count_n = bus.dir_down ? count_q - NUM_CNT_BITS'(1)
                                 : count_q + NUM_CNT_BITS'(1);
        end else begin
          flag_n = 1'b1;
          case (bus.mode)
            MODE_ONESHOT:  state_n = ST_DONE;
            MODE_SATURATE: count_n = count_q;
            default:       count_n = bus.dir_down ? bus.rollover_val : '0;
          endcase
        end
      end else begin
        pres_n = pres_q + PRESCALE_BITS'(1);
      end
    end
  end

  assign bus.count_out     = count_q;
  assign bus.tick          = tick_q;
  assign bus.rollover_flag = flag_q;
  assign bus.done          = (state_q == ST_DONE);
  assign bus.active        = (state_q == ST_RUN);

endmodule

// File: tb/tb_flex_timer.sv
// Directed bench for flex_timer. Stimulus pushes hand-computed expected
// outputs into a queue; the monitor pops one entry per falling edge.
module tb_flex_timer;

  logic clk;
  logic n_rst;

  flex_timer_if #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) bus ();

  flex_timer #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       tick;
    logic       flag;
    logic       done;
    logic       active;
    logic       tick_care;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.count_out !== e.cnt || (e.tick_care && bus.tick !== e.tick) ||
          bus.rollover_flag !== e.flag || bus.done !== e.done ||
          bus.active !== e.active) begin
        failures++;
        $display("FAIL %s: got cnt=%0d tick=%b flag=%b done=%b active=%b, want cnt=%0d tick=%b flag=%b done=%b active=%b",
                 e.name, bus.count_out, bus.tick, bus.rollover_flag, bus.done,
                 bus.active, e.cnt, e.tick, e.flag, e.done, e.active);
      end
    end
  end

  task automatic push(input logic [7:0] c, input logic t, input logic f,
                      input logic d, input logic a, input logic tc,
                      input string nm);
    exp_t e;
    e.cnt = c; e.tick = t; e.flag = f; e.done = d; e.active = a;
    e.tick_care = tc; e.name = nm;
    exp_q.push_back(e);
  endtask

  // one clock: inputs already set; expect these outputs after the next rising edge
  task automatic cyc(input logic [7:0] c, input logic t, input logic f,
                     input logic d, input logic a, input string nm);
    push(c, t, f, d, a, 1'b1, nm);
    @(negedge clk); #1;
  endtask

  task automatic cyc_nt(input logic [7:0] c, input logic f, input logic d,
                        input logic a, input string nm);
    push(c, 1'b0, f, d, a, 1'b0, nm);
    @(negedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.count_enable = 0;
    bus.dir_down = 0; bus.mode = 2'b00; bus.prescale_val = '0; bus.rollover_val = '0;
    @(negedge clk); #1;
    cyc(0, 0, 0, 0, 1, "reset");

    // up/wrap, rollover 3, tick every cycle
    n_rst = 1'b1; bus.rollover_val = 3; bus.count_enable = 1;
    cyc(1, 1, 0, 0, 1, "wrap_1");
    cyc(2, 1, 0, 0, 1, "wrap_2");
    cyc(3, 1, 0, 0, 1, "wrap_3");
    cyc(0, 1, 1, 0, 1, "wrap_roll");
    cyc(1, 1, 0, 0, 1, "wrap_again");

    // prescaler 2, rollover 5, with a 4-cycle enable gap
    bus.clear = 1;
    cyc(0, 0, 0, 0, 1, "ps_clear");
    bus.clear = 0; bus.prescale_val = 2; bus.rollover_val = 5;
    cyc(0, 0, 0, 0, 1, "ps_p1");
    cyc(0, 0, 0, 0, 1, "ps_p2");
    cyc(1, 1, 0, 0, 1, "ps_inc1");
    cyc(1, 0, 0, 0, 1, "ps_p1b");
    cyc(1, 0, 0, 0, 1, "ps_p2b");
    cyc(2, 1, 0, 0, 1, "ps_inc2");
    cyc(2, 0, 0, 0, 1, "ps_mid");
    bus.count_enable = 0;
    for (int i = 0; i < 4; i++) cyc(2, 0, 0, 0, 1, "ps_hold");
    bus.count_enable = 1;
    cyc(2, 0, 0, 0, 1, "ps_resume");
    cyc(3, 1, 0, 0, 1, "ps_inc3");

    // down one-shot from 4
    bus.prescale_val = 0; bus.mode = 2'b01; bus.dir_down = 1;
    bus.load = 1; bus.load_val = 4;
    cyc(4, 0, 0, 0, 1, "os_load");
    bus.load = 0;
    cyc(3, 1, 0, 0, 1, "os_3");
    cyc(2, 1, 0, 0, 1, "os_2");
    cyc(1, 1, 0, 0, 1, "os_1");
    cyc(0, 1, 0, 0, 1, "os_0");
    cyc(0, 1, 1, 1, 0, "os_done");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, "os_frozen");
    bus.mode = 2'b00;
    cyc(0, 0, 0, 1, 0, "os_mode_in_done");
    bus.mode = 2'b01; bus.load = 1; bus.load_val = 2;
    cyc(2, 0, 0, 0, 1, "os_reload");
    bus.load = 0; bus.count_enable = 0;
    cyc(2, 0, 0, 0, 1, "os_reload_hold");

    // saturate at 2, then reverse to 0, then wrap-down reload
    bus.clear = 1;
    cyc(0, 0, 0, 0, 1, "sat_clear");
    bus.clear = 0; bus.mode = 2'b10; bus.dir_down = 0; bus.rollover_val = 2;
    bus.count_enable = 1;
    cyc(1, 1, 0, 0, 1, "sat_1");
    cyc(2, 1, 0, 0, 1, "sat_2");
    cyc(2, 1, 1, 0, 1, "sat_hold_a");
    cyc(2, 1, 1, 0, 1, "sat_hold_b");
    bus.dir_down = 1;
    cyc(1, 1, 0, 0, 1, "sat_dn_1");
    cyc(0, 1, 0, 0, 1, "sat_dn_0");
    cyc(0, 1, 1, 0, 1, "sat_dn_hold_a");
    cyc(0, 1, 1, 0, 1, "sat_dn_hold_b");
    bus.mode = 2'b00;
    cyc(2, 1, 1, 0, 1, "wrapdn_reload");
    cyc(1, 1, 0, 0, 1, "wrapdn_1");

    // rollover 0 up/wrap, then priority of clear/load over a tick at terminal
    bus.dir_down = 0; bus.rollover_val = 0; bus.clear = 1;
    cyc(0, 0, 0, 0, 1, "rv0_clear");
    bus.clear = 0;
    cyc(0, 1, 1, 0, 1, "rv0_a");
    cyc(0, 1, 1, 0, 1, "rv0_b");
    bus.clear = 1; bus.load = 1; bus.load_val = 7;
    cyc_nt(0, 0, 0, 1, "prio_clear_load");
    bus.clear = 0;
    cyc_nt(7, 0, 0, 1, "prio_load");
    bus.load_val = 254;
    cyc_nt(254, 0, 0, 1, "load_254");
    bus.load = 0;
    cyc(255, 1, 0, 0, 1, "above_rv_255");
    cyc(0, 1, 0, 0, 1, "above_rv_wrap0");
    cyc(0, 1, 1, 0, 1, "above_rv_term");

    // async reset while in DONE
    bus.mode = 2'b01; bus.dir_down = 1; bus.load = 1; bus.load_val = 0;
    cyc(0, 0, 0, 0, 1, "ar_load0");
    bus.load = 0;
    cyc(0, 1, 1, 1, 0, "ar_done");
    push(0, 0, 0, 0, 1, 1'b1, "ar_async");
    @(posedge clk); #2;
    n_rst = 1'b0;
    @(negedge clk); #1;
    n_rst = 1'b1; bus.mode = 2'b00; bus.dir_down = 0; bus.rollover_val = 9;
    cyc(1, 1, 0, 0, 1, "ar_restart_1");
    cyc(2, 1, 0, 0, 1, "ar_restart_2");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
